// File: rtl/rgb_sched_pkg.sv
// Shared types for the RGB update scheduler: FSM states, colour struct,
// channel indices and the {R,B,G} word unpacker.
package rgb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] g;
    } colour_t;

    localparam logic CH_VIDEO = 1'b0;
    localparam logic CH_HOST  = 1'b1;

    // Colour words arrive as {R[23:16], B[15:8], G[7:0]}
    function automatic colour_t unpack_rgb(input logic [23:0] word);
        colour_t c;
        c.r = word[23:16];
        c.b = word[15:8];
        c.g = word[7:0];
        return c;
    endfunction

endpackage

// File: rtl/rgb_frame_sampler.sv
// Video-side requester: detects the sample pixel once per frame, divides by
// FRAME_DIV and holds the latest captured colour with pending/overflow flags.
module rgb_frame_sampler #(
    parameter int unsigned SAMPLE_X  = 640,
    parameter int unsigned SAMPLE_Y  = 360,
    parameter int unsigned FRAME_DIV = 120
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [10:0] set_x_i,
    input  logic [9:0]  set_y_i,
    input  logic [23:0] rgb_data_i,
    input  logic        ch0_clr_i,
    output logic        ch0_pend_o,
    output logic [23:0] ch0_rgb_o,
    output logic        sample_ovf_o
);

    localparam logic [10:0] MATCH_X  = 11'(SAMPLE_X);
    localparam logic [9:0]  MATCH_Y  = 10'(SAMPLE_Y);
    localparam logic [7:0]  CNT_LAST = 8'(FRAME_DIV - 1);

    logic        match_q, match_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic        ovf_q, ovf_d;

    // A capture on the same edge as the grant clear wins, and is not an overflow
    always_comb begin
        cnt_d  = cnt_q;
        buf_d  = buf_q;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ch0_clr_i) begin
            pend_d = 1'b0;
        end
        if (match_q && !match_prev_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = 8'd0;
                buf_d  = rgb_data_i;
                pend_d = 1'b1;
                if (pend_q && !ch0_clr_i) begin
                    ovf_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
            cnt_q        <= 8'd0;
            buf_q        <= 24'd0;
            pend_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            match_q      <= (set_x_i == MATCH_X) && (set_y_i == MATCH_Y);
            match_prev_q <= match_q;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ch0_pend_o   = pend_q;
    assign ch0_rgb_o    = buf_q;
    assign sample_ovf_o = ovf_q;

endmodule

// File: rtl/rgb_update_scheduler.sv
// Arbitrates video samples and host writes into the SK6805 colour registers,
// spacing updates by HOLDOFF cycles. Optional dimming: RGB_SCHED_DIM_EN.
module rgb_update_scheduler
    import rgb_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_X  = 640,
    parameter int unsigned SAMPLE_Y  = 360,
    parameter int unsigned FRAME_DIV = 120,
    parameter int unsigned HOLDOFF   = 3000
) (
    input  logic        clk_10MHz,
    input  logic        i_rst,
    input  logic [10:0] set_x,
    input  logic [9:0]  set_y,
    input  logic [23:0] rgb_data,
    input  logic        host_req,
    input  logic        host_led,
    input  logic [23:0] host_rgb,
`ifdef RGB_SCHED_DIM_EN
    input  logic [2:0]  dim_shift,
`endif
    output logic        host_ack,
    output logic [7:0]  R_In1,
    output logic [7:0]  G_In1,
    output logic [7:0]  B_In1,
    output logic [7:0]  R_In2,
    output logic [7:0]  G_In2,
    output logic [7:0]  B_In2,
    output logic        upd_pulse,
    output logic        sample_ovf
);

    localparam logic [15:0] HOLD_INIT = 16'(HOLDOFF - 1);

    sched_state_e state_q, state_d;
    logic         winner_q, winner_d;
    logic         rr_q, rr_d;
    logic [15:0]  hold_q, hold_d;
    colour_t      led1_q, led1_d, led2_q, led2_d;
    logic         ack_q, ack_d, upd_q, upd_d;
    logic         ch0_pend, ch0_clr;
    logic [23:0]  ch0_rgb;
    colour_t      src_col, new_col;

    rgb_frame_sampler #(
        .SAMPLE_X (SAMPLE_X),
        .SAMPLE_Y (SAMPLE_Y),
        .FRAME_DIV(FRAME_DIV)
    ) u_sampler (
        .clk_i       (clk_10MHz),
        .rst_ni      (i_rst),
        .set_x_i     (set_x),
        .set_y_i     (set_y),
        .rgb_data_i  (rgb_data),
        .ch0_clr_i   (ch0_clr),
        .ch0_pend_o  (ch0_pend),
        .ch0_rgb_o   (ch0_rgb),
        .sample_ovf_o(sample_ovf)
    );

    assign src_col = (winner_q == CH_HOST) ? unpack_rgb(host_rgb) : unpack_rgb(ch0_rgb);

`ifdef RGB_SCHED_DIM_EN
    assign new_col.r = src_col.r >> dim_shift;
    assign new_col.b = src_col.b >> dim_shift;
    assign new_col.g = src_col.g >> dim_shift;
`else
    assign new_col = src_col;
`endif

    // HOLD exits one cycle early so IDLE's arbitration cycle completes the hold-off
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_d     = rr_q;
        hold_d   = hold_q;
        led1_d   = led1_q;
        led2_d   = led2_q;
        ack_d    = 1'b0;
        upd_d    = 1'b0;
        ch0_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ch0_pend && host_req) begin
                    winner_d = rr_q;
                    state_d  = GRANT;
                end else if (ch0_pend) begin
                    winner_d = CH_VIDEO;
                    state_d  = GRANT;
                end else if (host_req) begin
                    winner_d = CH_HOST;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (winner_q == CH_HOST && !host_req) begin
                    state_d = IDLE;
                end else begin
                    if (winner_q == CH_VIDEO || !host_led) begin
                        led1_d = new_col;
                    end else begin
                        led2_d = new_col;
                    end
                    upd_d   = 1'b1;
                    ack_d   = (winner_q == CH_HOST);
                    ch0_clr = (winner_q == CH_VIDEO);
                    rr_d    = ~winner_q;
                    hold_d  = HOLD_INIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q <= 16'd1) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_10MHz or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            winner_q <= CH_VIDEO;
            rr_q     <= CH_VIDEO;
            hold_q   <= 16'd0;
            led1_q   <= '0;
            led2_q   <= '0;
            ack_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_q     <= rr_d;
            hold_q   <= hold_d;
            led1_q   <= led1_d;
            led2_q   <= led2_d;
            ack_q    <= ack_d;
            upd_q    <= upd_d;
        end
    end

    assign host_ack  = ack_q;
    assign upd_pulse = upd_q;
    assign R_In1     = led1_q.r;
    assign G_In1     = led1_q.g;
    assign B_In1     = led1_q.b;
    assign R_In2     = led2_q.r;
    assign G_In2     = led2_q.g;
    assign B_In2     = led2_q.b;

endmodule

// File: doc/rgb_update_scheduler.md
Name: rgb_update_scheduler

Overview:
- Sequences colour updates into the two-LED SK6805 driver (Driver_SK6805_0 inputs R_In1..B_In2).
- Arbitrates between two requesters:
  - ch0: a video sampler that captures rgb_data at a fixed pixel once every FRAME_DIV frames and drives LED1.
  - ch1: a host req/ack channel that writes either LED.
- Enforces a minimum hold-off between updates so the driver's latch/reset gap is never violated.
- Sits between the video timing path and the SK6805 driver.

Parameters:
- SAMPLE_X, 640, pixel column that triggers a video sample (11 bit).
- SAMPLE_Y, 360, pixel row that triggers a video sample (10 bit).
- FRAME_DIV, 120, video frames per ch0 update; legal range 1..255.
- HOLDOFF, 3000, clk_10MHz cycles (300 us) from one update to the next grant; minimum 1.

Ports:
- clk_10MHz  in  1  single clock, 10 MHz.
- i_rst  in  1  reset, asynchronous assert, active-low; synchronous release handled upstream.
- set_x  in  11  current pixel column.
- set_y  in  10  current pixel row.
- rgb_data  in  24  pixel colour, packed {R[23:16], B[15:8], G[7:0]}.
- host_req  in  1  ch1 request; level, held until ack.
- host_led  in  1  ch1 target: 0 = LED1, 1 = LED2.
- host_rgb  in  24  ch1 colour, same packing as rgb_data; stable while host_req = 1.
- host_ack  out  1  one-cycle pulse; ch1 data accepted.
- R_In1, G_In1, B_In1  out  8 each  LED1 colour to driver.
- R_In2, G_In2, B_In2  out  8 each  LED2 colour to driver.
- upd_pulse  out  1  one-cycle strobe on every output change.
- sample_ovf  out  1  sticky; a ch0 sample was overwritten before it was granted.

Behaviour:
- Reset (i_rst = 0, asynchronous): all colour outputs 0, host_ack 0, upd_pulse 0, sample_ovf 0, frame counter 0, ch0 pending cleared, FSM to IDLE, round-robin pointer to ch0.
- Sample detect:
  - match = (set_x == SAMPLE_X) && (set_y == SAMPLE_Y), registered.
  - Only the rising edge of match counts one frame, so a match held for several cycles counts once.
  - Frame counter runs 0..FRAME_DIV-1. On the edge where count == FRAME_DIV-1:
    - capture rgb_data into the ch0 buffer;
    - set ch0_pend;
    - reset the counter to 0.
  - If ch0_pend is already 1 at capture: the new data overwrites the buffer and sample_ovf is set (latest wins).
- FSM states: IDLE, GRANT, HOLD.
  - IDLE: if ch0_pend or host_req is set, go to GRANT and record the winner.
    - Both pending: round-robin; the winner's priority drops for the next contest.
    - Round-robin pointer after reset favours ch0.
  - GRANT (one cycle):
    - load the winner's colour into the target LED registers;
    - pulse upd_pulse;
    - if ch1 won, pulse host_ack in the same cycle; if ch0 won, clear ch0_pend;
    - go to HOLD and load hold counter = HOLDOFF-1.
  - HOLD: count down; at 0 go to IDLE. Requests arriving during HOLD wait.
- Latency: request seen in IDLE -> outputs and ack on the 2nd rising edge.
- Simultaneous capture and GRANT of ch0: the capture wins; ch0_pend stays 1 with the new data, and sample_ovf is not set.
- Unpacking: R = [23:16], B = [15:8], G = [7:0], for both channels.
- Untargeted LED keeps its value.
- host_req deasserted before ack: the request is withdrawn; no ack is issued.
- Reset asserted mid-HOLD or mid-GRANT: immediate return to reset state; a partial update is never visible.

Optional Feature:
- Macro RGB_SCHED_DIM_EN.
- When defined:
  - adds input dim_shift [2:0];
  - in GRANT, each 8-bit channel is logically right-shifted by dim_shift before loading;
  - dim_shift is sampled in GRANT only.
- When undefined: no port, colours loaded unmodified.

Decomposition:
- Package rgb_sched_pkg:
  - FSM state typedef (IDLE/GRANT/HOLD);
  - colour struct {r, b, g};
  - unpack function from the 24-bit {R,B,G} word;
  - channel index constants CH_VIDEO = 0, CH_HOST = 1.
- Sub-module rgb_frame_sampler: match register, edge detect, frame divider, ch0 buffer, pend/ovf flags; exposes ch0_pend, ch0_rgb, ch0_clr.

Test Plan:
- Reset, then FRAME_DIV = 3, HOLDOFF = 10, rgb_data = 0xFF00AA presented at (640,360) for 3 frames -> after the 3rd edge, R_In1 = 0xFF, B_In1 = 0x00, G_In1 = 0xAA; one upd_pulse; LED2 stays 0.
- Match held 5 consecutive cycles in one frame -> frame counter advances by exactly 1.
- host_req = 1, host_led = 1, host_rgb = 0x123456 -> host_ack on 2nd edge; R_In2 = 0x12, B_In2 = 0x34, G_In2 = 0x56.
- ch0_pend and host_req raised in the same cycle after reset:
  - ch0 granted first;
  - ch1 granted exactly HOLDOFF + 1 cycles later;
  - next tie -> ch0 wins again (pointer rotated back).
- Two samples captured during one HOLD -> sample_ovf = 1; only the second sample appears on LED1.
- i_rst pulled low mid-HOLD -> all colour outputs 0 asynchronously; a host request after release is granted in 2 cycles.
